// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with a circular return-address stack for call/return prediction.
// Optional macro PC_COMPRESSED_EN adds instr_is_16_i (2-byte step, 2-byte alignment).
module program_counter_ras #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         pc_enable_i,
  input  logic                         jump_en_i,
  input  logic                         call_en_i,
  input  logic                         ret_en_i,
`ifdef PC_COMPRESSED_EN
  input  logic                         instr_is_16_i,
`endif
  input  logic [XLEN-1:0]              jump_to_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [XLEN-1:0]              link_value_o,
  output logic [XLEN-1:0]              ras_top_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_overflow_o,
  output logic                         ras_underflow_o,
  output logic                         misalign_err_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef PC_COMPRESSED_EN
  localparam logic [XLEN-1:0] ALIGN_BITS = XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_BITS = XLEN'(3);
`endif

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mis_q, mis_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  step;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic             push;
  logic             ras_empty;
  logic             ras_full;

`ifdef PC_COMPRESSED_EN
  assign step = instr_is_16_i ? XLEN'(2) : XLEN'(4);
`else
  assign step = XLEN'(4);
`endif

  // ptr_q is the next free slot; when full it also addresses the oldest entry,
  // so a push while full overwrites the oldest return address.
  assign ras_empty    = (cnt_q == '0);
  assign ras_full     = (cnt_q == CNT_W'(RAS_DEPTH));
  assign link_value_o = pc_q + step;
  assign ras_top_o    = ras_empty ? '0 : ras_q[ptr_q - PTR_W'(1)];

  always_comb begin
    pc_d     = pc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mis_d    = 1'b0;
    push     = 1'b0;
    redirect = 1'b0;
    target   = jump_to_i;
    if (pc_enable_i) begin
      if (ret_en_i) begin
        redirect = 1'b1;
        if (!ras_empty) begin
          target = ras_top_o;
          ptr_d  = ptr_q - PTR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (jump_en_i) begin
        redirect = 1'b1;
        if (call_en_i) begin
          push  = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          if (ras_full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end else begin
        pc_d = link_value_o;
      end
      if (redirect) begin
        pc_d  = target & ~ALIGN_BITS;
        mis_d = |(target & ALIGN_BITS);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
      if (push) begin
        ras_q[ptr_q] <= link_value_o;
      end
    end
  end

  assign pc_o            = pc_q;
  assign ras_count_o     = cnt_q;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = unf_q;
  assign misalign_err_o  = mis_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Randomised bench for program_counter_ras against a queue-based stack model,
// plus directed scenarios with literal expectations.
module tb_program_counter_ras;

  localparam int DEPTH = 4;
`ifdef PC_COMPRESSED_EN
  localparam logic [31:0] ALIGN = 32'h1;
  localparam logic [31:0] MIS_TARGET_EXP = 32'h202;
`else
  localparam logic [31:0] ALIGN = 32'h3;
  localparam logic [31:0] MIS_TARGET_EXP = 32'h200;
`endif

  logic        clk = 1'b0;
  logic        reset_n, pc_enable, jump_en, call_en, ret_en;
  logic [31:0] jump_to;
  logic [31:0] pc, link_value, ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow, misalign_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf, m_unf, m_mis;

  always #5 clk = ~clk;

  program_counter_ras #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .pc_enable_i(pc_enable),
    .jump_en_i(jump_en),
    .call_en_i(call_en),
    .ret_en_i(ret_en),
`ifdef PC_COMPRESSED_EN
    .instr_is_16_i(1'b0),
`endif
    .jump_to_i(jump_to),
    .pc_o(pc),
    .link_value_o(link_value),
    .ras_top_o(ras_top),
    .ras_count_o(ras_count),
    .ras_overflow_o(ras_overflow),
    .ras_underflow_o(ras_underflow),
    .misalign_err_o(misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue, newest at the back, oldest dropped on overflow.
  task automatic modelStep();
    logic [31:0] t;
    m_mis = 1'b0;
    if (!reset_n) begin
      m_pc = 32'h0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (!pc_enable) return;
    if (ret_en) begin
      if (m_stack.size() > 0) t = m_stack.pop_back();
      else begin
        t = jump_to;
        m_unf = 1'b1;
      end
      m_pc  = t & ~ALIGN;
      m_mis = (t & ALIGN) != 0;
    end else if (jump_en) begin
      if (call_en) begin
        m_stack.push_back(m_pc + 32'd4);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
      end
      m_pc  = jump_to & ~ALIGN;
      m_mis = (jump_to & ALIGN) != 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic checkOutput();
    logic [31:0] top;
    top = (m_stack.size() > 0) ? m_stack[$] : 32'h0;
    chk("pc", pc, m_pc);
    chk("link_value", link_value, m_pc + 32'd4);
    chk("ras_top", ras_top, top);
    chk("ras_count", 32'(ras_count), 32'(m_stack.size()));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  task automatic applyStimulus(input logic rn, input logic en, input logic j,
                               input logic c, input logic r, input logic [31:0] to);
    reset_n   = rn;
    pc_enable = en;
    jump_en   = j;
    call_en   = c;
    ret_en    = r;
    jump_to   = to;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
  endtask

  task automatic jump(input logic [31:0] to);
    applyStimulus(1, 1, 1, 0, 0, to);
  endtask

  task automatic call(input logic [31:0] to);
    applyStimulus(1, 1, 1, 1, 0, to);
  endtask

  task automatic ret(input logic [31:0] to);
    applyStimulus(1, 1, 0, 0, 1, to);
  endtask

  initial begin
    logic [31:0] to;
    logic        rn, en, j, c, r;

    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 1, 32'h44);
    chk("lit_reset_pc", pc, 32'h0);
    chk("lit_reset_link", link_value, 32'h4);
    chk("lit_reset_count", 32'(ras_count), 32'h0);

    step(); step(); step();
    chk("lit_seq_pc", pc, 32'hC);
    chk("lit_seq_link", link_value, 32'h10);

    jump(32'h100);
    call(32'h400);
    chk("lit_call_pc", pc, 32'h400);
    chk("lit_call_top", ras_top, 32'h104);
    chk("lit_call_count", 32'(ras_count), 32'h1);
    ret(32'h0);
    chk("lit_ret_pc", pc, 32'h104);
    chk("lit_ret_count", 32'(ras_count), 32'h0);
    chk("lit_ret_flags", {30'h0, ras_overflow, ras_underflow}, 32'h0);

    jump(32'h10);
    for (int i = 2; i <= 6; i++) call(32'(i * 16));
    chk("lit_ovf_count", 32'(ras_count), 32'h4);
    chk("lit_ovf_flag", 32'(ras_overflow), 32'h1);
    ret(32'h0);
    chk("lit_pop1", pc, 32'h54);
    ret(32'h0); ret(32'h0); ret(32'h0);
    chk("lit_pop4", pc, 32'h24);
    ret(32'h800);
    chk("lit_unf_pc", pc, 32'h800);
    chk("lit_unf_flag", 32'(ras_underflow), 32'h1);

    jump(32'h203);
    chk("lit_mis_pc", pc, MIS_TARGET_EXP);
    chk("lit_mis_on", 32'(misalign_err), 32'h1);
    step();
    chk("lit_mis_off", 32'(misalign_err), 32'h0);

    call(32'h300);
    applyStimulus(1, 0, 1, 0, 1, 32'h900);
    chk("lit_hold_pc", pc, 32'h300);
    chk("lit_hold_count", 32'(ras_count), 32'h1);
    call(32'h500);
    applyStimulus(0, 1, 1, 1, 0, 32'h600);
    chk("lit_rst_pc", pc, 32'h0);
    chk("lit_rst_count", 32'(ras_count), 32'h0);
    chk("lit_rst_flags", {29'h0, ras_overflow, ras_underflow, misalign_err}, 32'h0);

    jump(32'hFFFF_FFFC);
    step();
    chk("lit_wrap_pc", pc, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 4) == 0);
      j  = ($urandom_range(0, 2) == 0);
      c  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 19))
        0:       to = 32'hFFFF_FFFC;
        1, 2, 3: to = $urandom();
        default: to = $urandom() & 32'hFFFF_FFFC;
      endcase
      applyStimulus(rn, en, j, c, r, to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
